// File: rtl/booth4_pp_sequencer_pkg.sv
// Shared definitions for the radix-4 Booth partial-product sequencer:
// Booth digit triple codes, FSM state encoding and the index-width helper.
package booth4_pp_sequencer_pkg;

  localparam logic [2:0] TRIP_ZERO_LO    = 3'b000;
  localparam logic [2:0] TRIP_PLUS_A_LO  = 3'b001;
  localparam logic [2:0] TRIP_PLUS_A_HI  = 3'b010;
  localparam logic [2:0] TRIP_PLUS_2A    = 3'b011;
  localparam logic [2:0] TRIP_MINUS_2A   = 3'b100;
  localparam logic [2:0] TRIP_MINUS_A_LO = 3'b101;
  localparam logic [2:0] TRIP_MINUS_A_HI = 3'b110;
  localparam logic [2:0] TRIP_ZERO_HI    = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic int idx_width(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/booth4_digit_enc.sv
// Combinational radix-4 Booth digit encoder: bit triple + sign-extended A -> multiple.
// Negative multiples leave as one's complement; pp_neg supplies the missing +1.
module booth4_digit_enc
  import booth4_pp_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       triple,
  input  logic [WIDTH+1:0] a_sext,
  output logic [WIDTH+1:0] pp_data,
  output logic             pp_neg
);

  always_comb begin
    pp_data = '0;
    pp_neg  = 1'b0;
    case (triple)
      TRIP_ZERO_LO, TRIP_ZERO_HI: begin
        pp_data = '0;
        pp_neg  = 1'b0;
      end
      TRIP_PLUS_A_LO, TRIP_PLUS_A_HI: begin
        pp_data = a_sext;
        pp_neg  = 1'b0;
      end
      TRIP_PLUS_2A: begin
        pp_data = a_sext << 1;
        pp_neg  = 1'b0;
      end
      TRIP_MINUS_2A: begin
        pp_data = ~(a_sext << 1);
        pp_neg  = 1'b1;
      end
      TRIP_MINUS_A_LO, TRIP_MINUS_A_HI: begin
        pp_data = ~a_sext;
        pp_neg  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/booth4_pp_sequencer.sv
// Iterative radix-4 Booth partial-product generator: one digit per pp handshake,
// registered outputs, digit 0 valid the cycle after the operand pair is accepted.
module booth4_pp_sequencer
  import booth4_pp_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDXW  = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             pp_valid,
  input  logic             pp_ready,
  output logic [WIDTH+1:0] pp_data,
  output logic             pp_neg,
  output logic [IDXW-1:0]  pp_idx,
  output logic             pp_last,
  output logic             busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH / 2 - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  nidx;

  logic             in_xfer, out_xfer, at_last;

  // Encoder source: live operands when loading digit 0, stored ones when stepping.
  logic [WIDTH-1:0] src_a, src_b;
  logic [IDXW-1:0]  enc_idx;
  logic [WIDTH:0]   bx;
  logic [2:0]       triple;
  logic [WIDTH+1:0] a_sext;
  logic [WIDTH+1:0] enc_data;
  logic             enc_neg;

  assign in_ready = (state_q == ST_IDLE);
  assign pp_valid = (state_q == ST_EMIT);
  assign busy     = (state_q == ST_EMIT);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = pp_valid & pp_ready;
  assign at_last  = (pp_idx == LAST_IDX);
  assign nidx     = pp_idx + IDX_ONE;

  assign src_a   = in_ready ? a_in : a_q;
  assign src_b   = in_ready ? b_in : b_q;
  assign enc_idx = in_ready ? '0 : nidx;
  assign bx      = {src_b, 1'b0};
  assign triple  = bx[{enc_idx, 1'b0} +: 3];
  // Extend before any shift so 2A of the most negative operand still fits.
  assign a_sext  = {{2{src_a[WIDTH-1]}}, src_a};

  booth4_digit_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .triple  (triple),
    .a_sext  (a_sext),
    .pp_data (enc_data),
    .pp_neg  (enc_neg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_xfer) state_d = ST_EMIT;
      ST_EMIT: if (out_xfer && at_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      pp_idx  <= '0;
      pp_data <= '0;
      pp_neg  <= 1'b0;
      pp_last <= 1'b0;
    end else if (in_xfer) begin
      a_q     <= a_in;
      b_q     <= b_in;
      pp_idx  <= '0;
      pp_data <= enc_data;
      pp_neg  <= enc_neg;
      pp_last <= (LAST_IDX == '0);
    end else if (out_xfer) begin
      if (at_last) begin
        pp_idx  <= '0;
        pp_data <= '0;
        pp_neg  <= 1'b0;
        pp_last <= 1'b0;
      end else begin
        pp_idx  <= nidx;
        pp_data <= enc_data;
        pp_neg  <= enc_neg;
        pp_last <= (nidx == LAST_IDX);
      end
    end
  end

endmodule
